// File: rtl/cordic_pkg.sv
// Shared constants, atan table and FSM state type for the CORDIC rotation/vectoring engines.
// Fixed-point format is signed Q8.24 throughout.
package cordic_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ACC_W  = 34;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned ATAN_N = 24;

  localparam logic signed [DATA_W-1:0] ONE     = 32'sd16777216;
  localparam logic signed [DATA_W-1:0] PI      = 32'sd52707179;
  localparam logic signed [DATA_W-1:0] HALF_PI = 32'sd26353589;

  // CORDIC gain after 24 micro-rotations, as a real and in Q8.24.
  localparam real                K_GAIN = 1.6467602581;
  localparam logic [DATA_W-1:0]  K_Q824 = 32'd27628053;

  // atan(2^-i) in Q8.24, round-to-nearest.
  localparam logic [DATA_W-1:0] ATAN_TABLE [ATAN_N] = '{
    32'd13176795, 32'd7778716, 32'd4110060, 32'd2086331,
    32'd1047214,  32'd524117,  32'd262123,  32'd131069,
    32'd65536,    32'd32768,   32'd16384,   32'd8192,
    32'd4096,     32'd2048,    32'd1024,    32'd512,
    32'd256,      32'd128,     32'd64,      32'd32,
    32'd16,       32'd8,       32'd4,       32'd2
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_ITER,
    ST_OUT
  } state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup; indices beyond the table return zero.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] atan_c_o
);

  always_comb begin
    atan_c_o = '0;
    if (32'(idx_i) < ATAN_N) begin
      atan_c_o = ATAN_TABLE[idx_i];
    end
  end

endmodule

// File: rtl/cordic_vectoring_engine.sv
// Iterative CORDIC vectoring engine: (X, Y) -> (K*|v|, atan2(Y, X)) in Q8.24,
// one micro-rotation per enabled clock.
module cordic_vectoring_engine
  import cordic_pkg::*;
#(
  parameter int unsigned ITER = 24
) (
  input  logic                     c_i,
  input  logic                     r_i,
  input  logic                     ce_i,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic        [DATA_W-1:0] mag_o,
  output logic signed [DATA_W-1:0] ang_o
);

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(ITER - 1);
  localparam logic signed [ACC_W-1:0] MAG_MAX  = ACC_W'(32'h7FFF_FFFF);

  state_e                     state_q, state_d;
  logic signed [ACC_W-1:0]    x_q, x_d;
  logic signed [ACC_W-1:0]    y_q, y_d;
  logic signed [DATA_W-1:0]   z_q, z_d;
  logic        [IDX_W-1:0]    i_q, i_d;
  logic                       zero_q, zero_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic        [DATA_W-1:0]   mag_q, mag_d;
  logic signed [DATA_W-1:0]   ang_q, ang_d;

  logic        [DATA_W-1:0]   atan_c;
  logic signed [DATA_W-1:0]   atan_s;
  logic signed [ACC_W-1:0]    x_sh;
  logic signed [ACC_W-1:0]    y_sh;

  cordic_atan_rom u_atan_rom (
    .idx_i    (i_q),
    .atan_c_o (atan_c)
  );

  assign atan_s = $signed(atan_c);
  assign x_sh   = x_q >>> i_q;
  assign y_sh   = y_q >>> i_q;

  // Next-state and datapath; everything holds while ce_i is low.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mag_d   = mag_q;
    ang_d   = ang_q;

    if (ce_i) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            x_d     = ACC_W'(x_i);
            y_d     = ACC_W'(y_i);
            zero_d  = (x_i == '0) && (y_i == '0);
            busy_d  = 1'b1;
            state_d = ST_PRE;
          end
        end

        // Fold left half-plane vectors into the right half-plane by +/-90 deg.
        ST_PRE: begin
          z_d = '0;
          if (x_q[ACC_W-1]) begin
            if (!y_q[ACC_W-1]) begin
              x_d = y_q;
              y_d = -x_q;
              z_d = HALF_PI;
            end else begin
              x_d = -y_q;
              y_d = x_q;
              z_d = -HALF_PI;
            end
          end
          i_d     = '0;
          state_d = ST_ITER;
        end

        ST_ITER: begin
          if (!y_q[ACC_W-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_s;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_s;
          end
          if (i_q == LAST_IDX) begin
            state_d = ST_OUT;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end

        ST_OUT: begin
          if (zero_q) begin
            mag_d = '0;
            ang_d = '0;
          end else begin
            if (x_q[ACC_W-1]) begin
              mag_d = '0;
            end else if (x_q > MAG_MAX) begin
              mag_d = 32'h7FFF_FFFF;
            end else begin
              mag_d = x_q[DATA_W-1:0];
            end
            ang_d = z_q;
          end
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge c_i) begin
    if (r_i) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign mag_o  = mag_q;
  assign ang_o  = ang_q;

endmodule
